bayer_to_gray: RTL and testbench
================================

// Module: bayer_to_gray
// PURPOSE
//  Converts the raw Bayer pixel stream from the camera capture stage into a 12-bit grayscale stream.
//  Bins each 2x2 Bayer quad into one output pixel, so a 1280x960 sensor frame becomes a 640x480 gray frame.
//  Sits directly upstream of the 3x3 convolution stage; its oDATA/oDVAL feed that stage's iDATA/iDVAL.
//  The 640-pixel output line length matches the convolution stage's line-buffer taps.
// PARAMETERS
//  IN_WIDTH      1280  sensor pixels per line; must be even
//  IN_HEIGHT     960   sensor lines per frame; must be even
//  BAYER_G_FIRST 1     1: G sits at (even x, even y) and (odd x, odd y); 0: G sits at (odd x, even y) and (even x, odd y)
// PORTS
//  iCLK    in   1   pixel clock
//  iRST    in   1   asynchronous, active-low reset
//  iFVAL   in   1   frame valid; low between frames
//  iDVAL   in   1   raw pixel valid, one beat per accepted pixel
//  iDATA   in   12  raw Bayer pixel, unsigned
//  iMODE   in   1   0: average of 4 quad pixels; 1: average of the 2 green pixels
//  oDATA   out  12  gray pixel, unsigned
//  oDVAL   out  1   gray pixel valid, single-cycle per output pixel
//  oX      out  10  output column of oDATA, 0..IN_WIDTH/2-1
//  oY      out  9   output row of oDATA, 0..IN_HEIGHT/2-1
//  oOVF    out  1   sticky flag: frame carried more than IN_WIDTH*IN_HEIGHT beats
// BEHAVIOUR
//  Reset (iRST low, async): oDATA=0, oDVAL=0, oX=0, oY=0, oOVF=0; x/y counters=0.
//  - Line-buffer and held-pixel contents are don't-care after reset.
//  Counters: a beat is accepted when iDVAL=1 and iFVAL=1.
//  - iDVAL while iFVAL=0 is ignored.
//  - x increments per accepted beat and wraps IN_WIDTH-1 -> 0; y increments on the wrap.
//  - iFVAL=0 (sampled) clears x and y synchronously, so a frame dropped mid-line restarts cleanly.
//  - The line buffer is not cleared by iFVAL.
//  Line buffer: holds the previous sensor line (IN_WIDTH x 12b), written on every accepted beat.
//  - A single-entry register holds the previous accepted pixel of the current line.
//  Output event: an accepted beat with x odd AND y odd, and y < IN_HEIGHT.
//  - Quad: P00=buf[x-1], P01=buf[x], P10=held pixel, P11=iDATA.
//  - iMODE=0: oDATA = (P00+P01+P10+P11) >> 2, 14-bit sum, truncating, never overflows.
//  - iMODE=1, BAYER_G_FIRST=1: oDATA = (P00+P11) >> 1, 13-bit sum.
//  - iMODE=1, BAYER_G_FIRST=0: oDATA = (P01+P10) >> 1, 13-bit sum.
//  - iMODE is sampled on the event beat; it may change at any time.
//  Latency: oDVAL, oDATA, oX=(x>>1), oY=(y>>1) are registered exactly 1 clock after the event beat.
//  - oDVAL is high for that one clock only.
//  - oDATA/oX/oY hold their last value while oDVAL=0.
//  Gaps: iDVAL may drop for any number of cycles mid-line.
//  - Held pixel, buffer and counters stay frozen; output timing shifts accordingly.
//  Rate: at most 1 output per 2 input beats; no backpressure; downstream accepts every oDVAL.
//  Overflow: a beat accepted with y >= IN_HEIGHT sets oOVF and produces no output.
//  - oOVF clears only on the rising edge of iFVAL (iFVAL sampled low, now high) or on reset.
//  Simultaneous iFVAL fall and iDVAL: the beat is ignored and the counters clear.
//  Reset mid-frame: outputs drop to reset values immediately.
//  - Output resumes at the first event beat after x,y re-reach odd/odd from 0.
// TESTING
//  T1 flat: iMODE=0, every pixel 12'h800, full frame -> 307200 oDVAL pulses, all oDATA=12'h800.
//     Last pulse has oX=639, oY=479.
//  T2 quad avg: row0 cols0/1 = 100/200, row1 cols0/1 = 300/403, iMODE=0 -> first oDATA=250.
//     That pulse comes 1 clk after the (1,1) beat, with oX=0, oY=0.
//  T3 green mode: same data, iMODE=1, BAYER_G_FIRST=1 -> oDATA=(100+403)>>1=251.
//     With BAYER_G_FIRST=0 -> oDATA=250.
//  T4 saturating sum: all pixels 12'hFFF, iMODE=0 -> oDATA=12'hFFF (no wrap).
//  T5 gaps/abort: random iDVAL gaps -> outputs identical to T2 apart from timing.
//     iFVAL dropped at x=517, y=3 -> next frame's first oDVAL has oX=0, oY=0.
//  T6 overflow/reset: 961 lines in one frame -> oOVF=1, no extra oDVAL; oOVF=0 after the next iFVAL rise.
//     iRST low mid-line -> oDVAL=0 and oDATA=0 within the same cycle.

Source files
------------

// File: rtl/bayer_to_gray.sv
// Bins each 2x2 Bayer quad of the raw sensor stream into one 12-bit gray pixel,
// with a one-line buffer holding the previous sensor line.
module bayer_to_gray #(
    parameter int IN_WIDTH      = 1280,
    parameter int IN_HEIGHT     = 960,
    parameter int BAYER_G_FIRST = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic [11:0] iDATA,
    input  logic        iMODE,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [9:0]  oX,
    output logic [8:0]  oY,
    output logic        oOVF
);

    localparam int XW = $clog2(IN_WIDTH);
    localparam int YW = $clog2(IN_HEIGHT + 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          fval_q;
    logic          ovf_q, ovf_d;
    logic          dval_q, dval_d;
    logic [11:0]   data_q, data_d;
    logic [9:0]    ox_q, ox_d;
    logic [8:0]    oy_q, oy_d;

    logic [11:0]   line_buf [IN_WIDTH];
    logic [11:0]   held_q;
    logic [11:0]   up_q;
    logic [11:0]   buf_rd;

    logic          accept;
    logic          x_last;
    logic          y_ovf;
    logic          quad_evt;
    logic [13:0]   sum4;
    logic [12:0]   sum_g;
    logic [11:0]   gray;

    assign accept   = iFVAL & iDVAL;
    assign x_last   = (x_q == XW'(IN_WIDTH - 1));
    // y saturates at IN_HEIGHT so an over-long frame can never wrap back into producing output
    assign y_ovf    = (y_q >= YW'(IN_HEIGHT));
    assign quad_evt = accept & x_q[0] & y_q[0] & ~y_ovf;
    assign buf_rd   = line_buf[x_q];

    // up_q captures the previous-line pixel at the even column before this line overwrites it
    assign sum4  = 14'(up_q) + 14'(buf_rd) + 14'(held_q) + 14'(iDATA);
    assign sum_g = (BAYER_G_FIRST != 0) ? (13'(up_q) + 13'(iDATA))
                                        : (13'(buf_rd) + 13'(held_q));
    assign gray  = iMODE ? sum_g[12:1] : sum4[13:2];

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!iFVAL) begin
            x_d = '0;
            y_d = '0;
        end else if (accept) begin
            if (x_last) begin
                x_d = '0;
                if (!y_ovf) y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (iFVAL && !fval_q) ovf_d = 1'b0;
        if (accept && y_ovf)  ovf_d = 1'b1;
    end

    always_comb begin
        dval_d = quad_evt;
        data_d = data_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        if (quad_evt) begin
            data_d = gray;
            ox_d   = 10'(x_q >> 1);
            oy_d   = 9'(y_q >> 1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            x_q    <= '0;
            y_q    <= '0;
            fval_q <= 1'b0;
            ovf_q  <= 1'b0;
            dval_q <= 1'b0;
            data_q <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            fval_q <= iFVAL;
            ovf_q  <= ovf_d;
            dval_q <= dval_d;
            data_q <= data_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (accept) begin
            line_buf[x_q] <= iDATA;
            if (!x_q[0]) begin
                held_q <= iDATA;
                up_q   <= buf_rd;
            end
        end
    end

    assign oDATA = data_q;
    assign oDVAL = dval_q;
    assign oX    = ox_q;
    assign oY    = oy_q;
    assign oOVF  = ovf_q;

endmodule

// File: tb/tb_bayer_to_gray.sv
// Directed bench for bayer_to_gray on a reduced 8x4 sensor frame, one instance per Bayer phase.
module tb_bayer_to_gray;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fval, dval, mode;
    logic [11:0] data;

    logic [11:0] d1_data, d0_data;
    logic        d1_dval, d0_dval, d1_ovf, d0_ovf;
    logic [9:0]  d1_x, d0_x;
    logic [8:0]  d1_y, d0_y;

    int passed = 0;
    int total  = 0;
    int pulses = 0;
    int snap;

    always #5 clk = ~clk;

    bayer_to_gray #(.IN_WIDTH(8), .IN_HEIGHT(4), .BAYER_G_FIRST(1)) dut_g1 (
        .iCLK(clk), .iRST(rst_n), .iFVAL(fval), .iDVAL(dval), .iDATA(data), .iMODE(mode),
        .oDATA(d1_data), .oDVAL(d1_dval), .oX(d1_x), .oY(d1_y), .oOVF(d1_ovf)
    );

    bayer_to_gray #(.IN_WIDTH(8), .IN_HEIGHT(4), .BAYER_G_FIRST(0)) dut_g0 (
        .iCLK(clk), .iRST(rst_n), .iFVAL(fval), .iDVAL(dval), .iDATA(data), .iMODE(mode),
        .oDATA(d0_data), .oDVAL(d0_dval), .oX(d0_x), .oY(d0_y), .oOVF(d0_ovf)
    );

    task automatic drive(input logic f, input logic v, input logic [11:0] d);
        fval = f;
        dval = v;
        data = d;
        @(negedge clk);
        if (d1_dval) pulses++;
    endtask

    task automatic beats(input logic [11:0] d, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, d);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        fval  = 1'b0;
        dval  = 1'b0;
        data  = '0;
        mode  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dval", 32'(d1_dval), 32'd0);
        chk("rst_data", 32'(d1_data), 32'd0);
        chk("rst_x",    32'(d1_x),    32'd0);
        chk("rst_y",    32'(d1_y),    32'd0);
        chk("rst_ovf",  32'(d1_ovf),  32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 12'd0);

        // Frame A, quad average: first quad 100/200 over 300/403, bottom rows saturated
        drive(1'b1, 1'b0, 12'd0);
        drive(1'b1, 1'b1, 12'd100);
        drive(1'b1, 1'b1, 12'd200);
        beats(12'd0, 6);
        drive(1'b1, 1'b1, 12'd300);
        chk("a_no_evt_even", 32'(d1_dval), 32'd0);
        drive(1'b1, 1'b1, 12'd403);
        chk("a_q_dval",  32'(d1_dval), 32'd1);
        chk("a_q_g1",    32'(d1_data), 32'd250);
        chk("a_q_g0",    32'(d0_data), 32'd250);
        chk("a_q_x",     32'(d1_x),    32'd0);
        chk("a_q_y",     32'(d1_y),    32'd0);
        beats(12'd0, 2);
        chk("a_q1_data", 32'(d1_data), 32'd0);
        chk("a_q1_x",    32'(d1_x),    32'd1);
        beats(12'd0, 4);
        beats(12'hFFF, 16);
        chk("a_sat_data", 32'(d1_data), 32'hFFF);
        chk("a_last_x",   32'(d1_x),    32'd3);
        chk("a_last_y",   32'(d1_y),    32'd1);
        chk("a_pulses",   32'(pulses),  32'd8);
        drive(1'b1, 1'b0, 12'd0);
        chk("a_idle_dval", 32'(d1_dval), 32'd0);
        chk("a_idle_hold", 32'(d1_data), 32'hFFF);
        chk("a_no_ovf",    32'(d1_ovf),  32'd0);

        // Frame B, green mode with iDVAL gaps, aborted mid-line
        drive(1'b0, 1'b0, 12'd0);
        mode = 1'b1;
        drive(1'b1, 1'b1, 12'd100);
        drive(1'b1, 1'b0, 12'd0);
        drive(1'b1, 1'b1, 12'd200);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 12'd0);
            drive(1'b1, 1'b1, 12'd0);
        end
        drive(1'b1, 1'b1, 12'd300);
        drive(1'b1, 1'b0, 12'd0);
        drive(1'b1, 1'b0, 12'd0);
        chk("b_gap_dval", 32'(d1_dval), 32'd0);
        drive(1'b1, 1'b1, 12'd403);
        chk("b_g1_dval", 32'(d1_dval), 32'd1);
        chk("b_g1_data", 32'(d1_data), 32'd251);
        chk("b_g0_data", 32'(d0_data), 32'd250);
        beats(12'd0, 3);
        drive(1'b0, 1'b1, 12'hFFF);
        chk("b_abort_dval", 32'(d1_dval), 32'd0);
        chk("b_abort_x",    32'(d1_x),    32'd1);

        // Next frame restarts at the origin
        mode = 1'b0;
        beats(12'd10, 8);
        drive(1'b1, 1'b1, 12'd20);
        drive(1'b1, 1'b1, 12'd30);
        chk("c_dval", 32'(d1_dval), 32'd1);
        chk("c_data", 32'(d1_data), 32'd17);
        chk("c_x",    32'(d1_x),    32'd0);
        chk("c_y",    32'(d1_y),    32'd0);

        // Over-long frame: five sensor lines
        drive(1'b0, 1'b0, 12'd0);
        snap = pulses;
        beats(12'h123, 32);
        chk("o_pulses", 32'(pulses - snap), 32'd8);
        chk("o_pre_ovf", 32'(d1_ovf), 32'd0);
        drive(1'b1, 1'b1, 12'h123);
        chk("o_ovf_set",  32'(d1_ovf),  32'd1);
        chk("o_ovf_dval", 32'(d1_dval), 32'd0);
        beats(12'h123, 7);
        chk("o_no_extra", 32'(pulses - snap), 32'd8);
        drive(1'b0, 1'b0, 12'd0);
        chk("o_ovf_sticky", 32'(d1_ovf), 32'd1);
        drive(1'b1, 1'b0, 12'd0);
        chk("o_ovf_clr", 32'(d1_ovf), 32'd0);

        // Reset mid-line
        beats(12'h200, 10);
        chk("r_pre_dval", 32'(d1_dval), 32'd1);
        chk("r_pre_data", 32'(d1_data), 32'h200);
        rst_n = 1'b0;
        #1;
        chk("r_async_dval", 32'(d1_dval), 32'd0);
        chk("r_async_data", 32'(d1_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beats(12'h200, 8);
        drive(1'b1, 1'b1, 12'h100);
        drive(1'b1, 1'b1, 12'h100);
        chk("r_post_dval", 32'(d1_dval), 32'd1);
        chk("r_post_data", 32'(d1_data), 32'h180);
        chk("r_post_x",    32'(d1_x),    32'd0);
        chk("r_post_y",    32'(d1_y),    32'd0);

        drive(1'b0, 1'b0, 12'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
